wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: WB_FIFO_DEPTH, default 2; number of buffered long-latency writeback entries.
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  reset; synchronous, active-high.
REQ-004 alu_valid_i  in  1  single-cycle (ALU) writeback request; no backpressure.
REQ-005 alu_rd_i  in  5  ALU destination register index.
REQ-006 alu_data_i  in  32  ALU result.
REQ-007 ltu_valid_i  in  1  long-latency unit (load/mul/div) writeback request.
REQ-008 ltu_ready_o  out  1  block can accept an LTU request this cycle.
REQ-009 ltu_rd_i  in  5  LTU destination register index.
REQ-010 ltu_data_i  in  32  LTU result.
REQ-011 dataW_o  out  32  register-file write data, registered.
REQ-012 rsW_o  out  5  register-file write index, registered.
REQ-013 RegWEn_o  out  1  register-file write enable, registered.
REQ-014 busy_o  out  1  high when any LTU entry is buffered.

Function
REQ-015 Outputs dataW_o/rsW_o/RegWEn_o shall update only on the rising edge of clk_i; write latency is one cycle from request to output.
REQ-016 The LTU handshake shall complete on a cycle with ltu_valid_i=1 and ltu_ready_o=1; the LTU holds rd/data stable while valid=1 and ready=0.
REQ-017 ltu_ready_o shall equal (rst_i=0) AND (count < WB_FIFO_DEPTH); it is combinational from registered count only.
REQ-018 Priority per cycle: alu_valid_i=1 -> ALU entry is written; else FIFO non-empty -> head is popped and written; else accepted LTU request bypasses the FIFO and is written; else RegWEn_o=0.
REQ-019 An accepted LTU request not written the same cycle shall be pushed to the FIFO tail.
REQ-020 LTU entries shall be written in acceptance order; no reordering or drop.
REQ-021 Push and pop in the same cycle shall leave count unchanged; count range 0..WB_FIFO_DEPTH, never wraps.
REQ-022 Any selected entry with rd=0 shall produce RegWEn_o=0 (x0 write suppressed) but still consumes its slot/cycle.
REQ-023 When RegWEn_o=0, dataW_o and rsW_o shall hold their previous values.
REQ-024 Continuous alu_valid_i may starve the FIFO indefinitely; this is accepted behaviour and the issue logic guarantees ALU gaps.
REQ-025 busy_o shall equal (count != 0), registered-derived.

Reset
REQ-026 While rst_i=1 at a clock edge: count=0, FIFO contents invalidated, RegWEn_o=0, dataW_o=0, rsW_o=0.
REQ-027 Reset asserted mid-operation shall discard all buffered and in-flight entries; no write occurs on the edge where rst_i=1.
REQ-028 ltu_ready_o shall be 0 while rst_i=1 and 1 on the first cycle after release.

Structure
REQ-029 WB_FIFO_DEPTH and typedef wb_entry_t {rd[4:0], data[31:0]} shall live in the shared package riscv_pkg.
REQ-030 The buffer shall be a separate sub-module wb_fifo (sync, pointer-based, full/empty/count outputs).
REQ-031 The arbitration/select logic shall remain in wb_arbiter; rsW_o/dataW_o/RegWEn_o connect directly to the register-file write port.

Verification
REQ-032 ALU only: alu_valid=1, rd=5, data=0xDEADBEEF -> next edge RegWEn_o=1, rsW_o=5, dataW_o=0xDEADBEEF.
REQ-033 Bypass: FIFO empty, alu_valid=0, ltu_valid=1, rd=7, data=0x12 -> next edge write x7=0x12, busy_o stays 0.
REQ-034 Conflict: same cycle ALU rd=1/0xA and LTU rd=2/0xB -> x1=0xA written, then x2=0xB next cycle, busy_o high for one cycle.
REQ-035 Full: ALU busy 4 cycles, LTU offers rd=3,4,5 -> 3,4 accepted, ltu_ready_o=0 for rd=5 until first pop; final write order x3,x4,x5.
REQ-036 x0: ALU rd=0, data=0xFFFFFFFF -> RegWEn_o=0, rsW_o/dataW_o unchanged.
REQ-037 Reset mid-operation: two entries buffered, rst_i=1 one cycle -> count=0, no writes, ltu_ready_o=1 after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the writeback path.
// Holds the writeback entry layout and the default LTU buffer depth.
package riscv_pkg;

    localparam int WB_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    // Writes to x0 are architecturally discarded.
    function automatic logic is_x0(input logic [4:0] rd);
        return (rd == 5'd0);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous pointer-based FIFO buffering LTU writebacks that lose arbitration.
// Read data is the current head (combinational); push/pop take effect on the rising edge.
module wb_fifo
    import riscv_pkg::wb_entry_t;
#(
    parameter  int DEPTH = riscv_pkg::WB_FIFO_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  wb_entry_t     push_dat_i,
    input  logic          pop_i,
    output wb_entry_t     head_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    // Guard against overflow/underflow so count stays within 0..DEPTH.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU first, then buffered LTU entries, then LTU bypass.
// One-cycle registered write latency; LTU is backpressured only when the FIFO is full.
module wb_arbiter
    import riscv_pkg::wb_entry_t;
    import riscv_pkg::is_x0;
#(
    parameter int WB_FIFO_DEPTH = riscv_pkg::WB_FIFO_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    input  logic        ltu_valid_i,
    output logic        ltu_ready_o,
    input  logic [4:0]  ltu_rd_i,
    input  logic [31:0] ltu_data_i,
    output logic [31:0] dataW_o,
    output logic [4:0]  rsW_o,
    output logic        RegWEn_o,
    output logic        busy_o
);

    localparam int CW = $clog2(WB_FIFO_DEPTH + 1);

    wb_entry_t     head_dat, sel_dat, ltu_dat;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          ltu_acc, sel_vld, push, pop;
    logic [31:0]   data_q, data_d;
    logic [4:0]    rs_q, rs_d;
    logic          wen_q, wen_d;

    assign ltu_dat     = '{rd: ltu_rd_i, data: ltu_data_i};
    assign ltu_ready_o = !rst_i && !fifo_full;
    assign ltu_acc     = ltu_valid_i && ltu_ready_o;
    assign busy_o      = (fifo_count != '0);

    wb_fifo #(.DEPTH(WB_FIFO_DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push),
        .push_dat_i (ltu_dat),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // An accepted LTU entry is buffered whenever something older or the ALU owns the port.
    always_comb begin
        sel_vld = 1'b0;
        sel_dat = '0;
        push    = 1'b0;
        pop     = 1'b0;
        if (alu_valid_i) begin
            sel_vld = 1'b1;
            sel_dat = '{rd: alu_rd_i, data: alu_data_i};
            push    = ltu_acc;
        end else if (!fifo_empty) begin
            sel_vld = 1'b1;
            sel_dat = head_dat;
            pop     = !rst_i;
            push    = ltu_acc;
        end else if (ltu_acc) begin
            sel_vld = 1'b1;
            sel_dat = ltu_dat;
        end
    end

    always_comb begin
        wen_d  = 1'b0;
        rs_d   = rs_q;
        data_d = data_q;
        if (sel_vld && !is_x0(sel_dat.rd)) begin
            wen_d  = 1'b1;
            rs_d   = sel_dat.rd;
            data_d = sel_dat.data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wen_q  <= 1'b0;
            rs_q   <= '0;
            data_q <= '0;
        end else begin
            wen_q  <= wen_d;
            rs_q   <= rs_d;
            data_q <= data_d;
        end
    end

    assign RegWEn_o = wen_q;
    assign rsW_o    = rs_q;
    assign dataW_o  = data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes are queued at stimulus time and
// matched by a monitor against each RegWEn_o pulse.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        ltu_valid_i;
    logic        ltu_ready_o;
    logic [4:0]  ltu_rd_i;
    logic [31:0] ltu_data_i;
    logic [31:0] dataW_o;
    logic [4:0]  rsW_o;
    logic        RegWEn_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [36:0] exp_q [$];

    always #5 clk = ~clk;

    wb_arbiter #(.WB_FIFO_DEPTH(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .alu_valid_i (alu_valid_i),
        .alu_rd_i    (alu_rd_i),
        .alu_data_i  (alu_data_i),
        .ltu_valid_i (ltu_valid_i),
        .ltu_ready_o (ltu_ready_o),
        .ltu_rd_i    (ltu_rd_i),
        .ltu_data_i  (ltu_data_i),
        .dataW_o     (dataW_o),
        .rsW_o       (rsW_o),
        .RegWEn_o    (RegWEn_o),
        .busy_o      (busy_o)
    );

    task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (RegWEn_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {rsW_o, dataW_o}, 37'h1F_FFFF_FFFF);
            end else begin
                check("write", {rsW_o, dataW_o}, exp_q.pop_front());
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
        ltu_valid_i = 1'b0; ltu_rd_i = '0; ltu_data_i = '0;
    endtask

    // Full-FIFO scenario tables: ALU busy 4 cycles, LTU offers x3,x4,x5.
    logic [4:0]  full_alu_rd [4] = '{5'd10, 5'd11, 5'd12, 5'd13};
    logic        full_rdy    [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [4:0]  full_ltu_rd [3] = '{5'd3, 5'd4, 5'd5};

    initial begin
        int j;
        idle_inputs();
        rst_i = 1'b1;
        cycle(); cycle();
        @(negedge clk);
        check("rst_wen",   {36'd0, RegWEn_o},    37'd0);
        check("rst_rs",    {32'd0, rsW_o},       37'd0);
        check("rst_data",  {5'd0, dataW_o},      37'd0);
        check("rst_ready", {36'd0, ltu_ready_o}, 37'd0);
        check("rst_busy",  {36'd0, busy_o},      37'd0);
        cycle();
        rst_i = 1'b0;
        #1;
        check("ready_after_rst", {36'd0, ltu_ready_o}, 37'd1);

        // ALU only
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        cycle();
        idle_inputs();

        // LTU bypass with empty FIFO
        ltu_valid_i = 1'b1; ltu_rd_i = 5'd7; ltu_data_i = 32'h12;
        #1 check("bypass_ready", {36'd0, ltu_ready_o}, 37'd1);
        exp_q.push_back({5'd7, 32'h12});
        cycle();
        idle_inputs();
        @(negedge clk);
        check("bypass_busy", {36'd0, busy_o}, 37'd0);
        cycle();

        // Same-cycle conflict
        alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'hA;
        ltu_valid_i = 1'b1; ltu_rd_i = 5'd2; ltu_data_i = 32'hB;
        exp_q.push_back({5'd1, 32'hA});
        exp_q.push_back({5'd2, 32'hB});
        cycle();
        idle_inputs();
        @(negedge clk);
        check("conflict_busy1", {36'd0, busy_o}, 37'd1);
        cycle();
        @(negedge clk);
        check("conflict_busy0", {36'd0, busy_o}, 37'd0);
        cycle();

        // FIFO full backpressure
        for (int k = 0; k < 4; k++) exp_q.push_back({full_alu_rd[k], 32'h100 + 32'(k)});
        for (int k = 0; k < 3; k++) exp_q.push_back({full_ltu_rd[k], 32'(full_ltu_rd[k]) << 8});
        j = 0;
        for (int c = 0; c < 6; c++) begin
            alu_valid_i = (c < 4);
            alu_rd_i    = (c < 4) ? full_alu_rd[c] : 5'd0;
            alu_data_i  = 32'h100 + 32'(c);
            ltu_valid_i = (j < 3);
            ltu_rd_i    = (j < 3) ? full_ltu_rd[j] : 5'd0;
            ltu_data_i  = 32'(ltu_rd_i) << 8;
            #1 check($sformatf("full_ready_c%0d", c), {36'd0, ltu_ready_o}, {36'd0, full_rdy[c]});
            if (full_rdy[c]) j++;
            cycle();
        end
        idle_inputs();
        for (int w = 0; w < 20 && (busy_o || exp_q.size() != 0); w++) cycle();
        check("full_drained", 37'(exp_q.size()), 37'd0);
        cycle();

        // x0 write suppressed, previous write (x5=0x500) held
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'hFFFFFFFF;
        cycle();
        idle_inputs();
        @(negedge clk);
        check("x0_wen",  {36'd0, RegWEn_o}, 37'd0);
        check("x0_hold", {rsW_o, dataW_o},  {5'd5, 32'h500});
        cycle();

        // Reset mid-operation with two entries buffered
        for (int k = 0; k < 2; k++) begin
            alu_valid_i = 1'b1; alu_rd_i = 5'd20 + 5'(k); alu_data_i = 32'h2000 + 32'(k);
            ltu_valid_i = 1'b1; ltu_rd_i = 5'd8 + 5'(k);  ltu_data_i = 32'h8000 + 32'(k);
            exp_q.push_back({5'd20 + 5'(k), 32'h2000 + 32'(k)});
            cycle();
        end
        idle_inputs();
        #1 check("pre_rst_busy", {36'd0, busy_o}, 37'd1);
        rst_i = 1'b1;
        cycle();
        @(negedge clk);
        check("midrst_wen",   {36'd0, RegWEn_o},    37'd0);
        check("midrst_busy",  {36'd0, busy_o},      37'd0);
        check("midrst_ready", {36'd0, ltu_ready_o}, 37'd0);
        rst_i = 1'b0;
        #1 check("midrst_ready_rel", {36'd0, ltu_ready_o}, 37'd1);
        for (int w = 0; w < 4; w++) cycle();
        check("midrst_busy_after", {36'd0, busy_o}, 37'd0);
        check("sb_empty", 37'(exp_q.size()), 37'd0);

        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $finish;
    end

endmodule
